// File: rtl/alu_issue_collect_if.sv
// Command and response channels between a command source and alu_issue_collect.
// The command source uses the master modport; the issue/collect block uses slave.
interface alu_issue_collect_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [4:0]       cmd_shift;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_issue_collect.sv
// Issue/collect front end for a fixed-latency pipelined ALU with no flow control.
// Commands are accepted against a credit count so every in-flight op is guaranteed
// a response FIFO slot; results are captured LATENCY cycles after issue and
// returned in issue order.
// Optional feature: define ALU_ISSUE_DIVZERO_EN to intercept DIV by zero and
// return all-ones with rsp_err set instead of the ALU's value.
module alu_issue_collect #(
    parameter int WIDTH     = 32,
    parameter int LATENCY   = 2,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_collect_if.slave bus,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             busy
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [3:0] OP_DIV = 4'd7;

    // ---------------- credit accounting ----------------
    logic [CNT_W-1:0] reserved_reg, reserved_next;
    logic             cmd_ready_reg;
    logic             accept;
    logic             pop;
    logic             rsp_valid;

    assign accept        = bus.cmd_valid && cmd_ready_reg;
    assign pop           = rsp_valid && bus.rsp_ready;
    assign bus.cmd_ready = cmd_ready_reg;
    assign busy          = (reserved_reg != '0);

    // Credit count: one per accepted op, released when its response is popped
    always_comb begin
        reserved_next = reserved_reg;
        if (accept && !pop)
            reserved_next = reserved_reg + 1'b1;
        else if (!accept && pop)
            reserved_next = reserved_reg - 1'b1;
    end

    // Credit register and its registered ready decode (no path from cmd_valid/rsp_ready)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved_reg  <= '0;
            cmd_ready_reg <= 1'b1;
        end else begin
            reserved_reg  <= reserved_next;
            cmd_ready_reg <= (reserved_next < CNT_W'(RSP_DEPTH));
        end
    end

    // ---------------- issue stage ----------------
    logic issue_bypass;
`ifdef ALU_ISSUE_DIVZERO_EN
    assign issue_bypass = (bus.cmd_opcode == OP_DIV) && (bus.cmd_b == '0);
`else
    assign issue_bypass = 1'b0;
`endif

    // ALU drive registers: the accepted command, or ADD 0+0 when idle/bypassed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
        end else if (accept && !issue_bypass) begin
            alu_opcode     <= bus.cmd_opcode;
            alu_input1     <= bus.cmd_a;
            alu_input2     <= bus.cmd_b;
            alu_shiftValue <= bus.cmd_shift;
        end else begin
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
        end
    end

    // ---------------- tag pipeline ----------------
    logic             stg_valid_reg  [0:LATENCY];
    logic [TAG_W-1:0] stg_tag_reg    [0:LATENCY];
    logic             stg_bypass_reg [0:LATENCY];

    // Stage 0 lines up with the alu_* drive registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid_reg[0]  <= 1'b0;
            stg_tag_reg[0]    <= '0;
            stg_bypass_reg[0] <= 1'b0;
        end else begin
            stg_valid_reg[0]  <= accept;
            stg_tag_reg[0]    <= bus.cmd_tag;
            stg_bypass_reg[0] <= accept && issue_bypass;
        end
    end

    generate
        for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_stage
            // Advance one stage per cycle alongside the ALU's internal pipeline
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg_valid_reg[gi]  <= 1'b0;
                    stg_tag_reg[gi]    <= '0;
                    stg_bypass_reg[gi] <= 1'b0;
                end else begin
                    stg_valid_reg[gi]  <= stg_valid_reg[gi-1];
                    stg_tag_reg[gi]    <= stg_tag_reg[gi-1];
                    stg_bypass_reg[gi] <= stg_bypass_reg[gi-1];
                end
            end
        end
    endgenerate

    // ---------------- capture ----------------
    logic             push;
    logic [WIDTH-1:0] push_result;
    logic [3:0]       push_flags;

    assign push        = stg_valid_reg[LATENCY];
    assign push_result = stg_bypass_reg[LATENCY] ? {WIDTH{1'b1}} : alu_result;
    assign push_flags  = stg_bypass_reg[LATENCY] ? 4'd0 : alu_flags;

    // ---------------- response FIFO (first-word fall-through) ----------------
    logic [WIDTH-1:0] result_mem [0:RSP_DEPTH-1];
    logic [3:0]       flags_mem  [0:RSP_DEPTH-1];
    logic [TAG_W-1:0] tag_mem    [0:RSP_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign rsp_valid = (count_reg != '0);

    // Pointer and occupancy bookkeeping; push and pop may coincide at any level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage write; cleared on reset so response outputs read back as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                result_mem[i] <= '0;
                flags_mem[i]  <= '0;
                tag_mem[i]    <= '0;
            end
        end else if (push) begin
            result_mem[wr_ptr_reg] <= push_result;
            flags_mem[wr_ptr_reg]  <= push_flags;
            tag_mem[wr_ptr_reg]    <= stg_tag_reg[LATENCY];
        end
    end

`ifdef ALU_ISSUE_DIVZERO_EN
    logic err_mem [0:RSP_DEPTH-1];

    // Error bit travels with its FIFO entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++)
                err_mem[i] <= 1'b0;
        end else if (push) begin
            err_mem[wr_ptr_reg] <= stg_bypass_reg[LATENCY];
        end
    end

    assign bus.rsp_err = err_mem[rd_ptr_reg];
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = result_mem[rd_ptr_reg];
    assign bus.rsp_flags  = flags_mem[rd_ptr_reg];
    assign bus.rsp_tag    = tag_mem[rd_ptr_reg];

    // Credit makes overflow impossible; catch it if that invariant is ever broken
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_reg == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_alu_issue_collect.sv
// Scoreboard bench for alu_issue_collect with a behavioural 2-stage ALU attached.
module tb_alu_issue_collect;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_input1, alu_input2;
    logic [4:0]  alu_shiftValue;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        busy;

    alu_issue_collect_if #(.WIDTH(32), .TAG_W(4)) bus ();

    alu_issue_collect dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .alu_opcode     (alu_opcode),
        .alu_input1     (alu_input1),
        .alu_input2     (alu_input2),
        .alu_shiftValue (alu_shiftValue),
        .alu_result     (alu_result),
        .alu_flags      (alu_flags),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural ALU: input register + output register ----------------
    logic [3:0]  a_op;
    logic [31:0] a_x, a_y;
    logic [4:0]  a_sh;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_op <= '0; a_x <= '0; a_y <= '0; a_sh <= '0;
            alu_result <= '0; alu_flags <= '0;
        end else begin
            a_op <= alu_opcode; a_x <= alu_input1; a_y <= alu_input2; a_sh <= alu_shiftValue;
            case (a_op)
                4'd0: begin
                    alu_result <= a_x + a_y;
                    alu_flags <= {({1'b0, a_x} + {1'b0, a_y}) >> 32 != 33'd0, (a_x + a_y) == 32'd0,
                                  (a_x[31] == a_y[31]) && ((a_x + a_y) >> 31 != {31'd0, a_x[31]}), (a_x + a_y) >> 31 != 32'd0};
                end
                4'd1: begin
                    alu_result <= a_x - a_y;
                    alu_flags <= {a_x < a_y, (a_x - a_y) == 32'd0,
                                  (a_x[31] != a_y[31]) && ((a_x - a_y) >> 31 != {31'd0, a_x[31]}), (a_x - a_y) >> 31 != 32'd0};
                end
                4'd2: alu_result <= a_x * a_y;
                4'd3: alu_result <= (a_sh == 5'd0) ? a_x : ((a_x << a_sh) | (a_x >> (6'd32 - {1'b0, a_sh})));
                4'd4: alu_result <= a_x | a_y;
                4'd5: alu_result <= ($signed(a_x) > $signed(a_y)) ? 32'd1 : 32'd0;
                4'd6: alu_result <= ~(a_x | a_y);
                4'd7: alu_result <= (a_y == 32'd0) ? 32'd0 : a_x / a_y;
                4'd8: alu_result <= a_x << a_sh;
                4'd9: alu_result <= (a_sh == 5'd0) ? a_x : ((a_x >> a_sh) | (a_x << (6'd32 - {1'b0, a_sh})));
                default: alu_result <= 32'd0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic [3:0]  mask;
        logic [3:0]  tag;
        logic        err;
        int          acc;
        bit          chk_lat;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation for every accepted response, checks hold while stalled
    initial begin
        bit          stall_prev = 0;
        logic [31:0] held_res;
        logic [3:0]  held_tag;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
                    check("hold_result", bus.rsp_result, held_res);
                    check("hold_tag", {28'd0, bus.rsp_tag}, {28'd0, held_tag});
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual tag=%0h result=%h required no response", bus.rsp_tag, bus.rsp_result);
                    end else begin
                        e = exp_q.pop_front();
                        $display("rsp tag=%0h result=%h flags=%b err=%b cycle=%0d", bus.rsp_tag, bus.rsp_result, bus.rsp_flags, bus.rsp_err, cyc);
                        check("rsp_result", bus.rsp_result, e.res);
                        check("rsp_tag", {28'd0, bus.rsp_tag}, {28'd0, e.tag});
                        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                        if (e.mask != 4'd0)
                            check("rsp_flags", {28'd0, bus.rsp_flags & e.mask}, {28'd0, e.flags & e.mask});
                        if (e.chk_lat)
                            check("latency", cyc - e.acc, 32'd4);
                    end
                end
                stall_prev = bus.rsp_valid && !bus.rsp_ready;
                held_res   = bus.rsp_result;
                held_tag   = bus.rsp_tag;
            end
        end
    end

    // Present one command until accepted; the expectation is queued at acceptance
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] tag, input logic [31:0] r,
                        input logic [3:0] fl, input logic [3:0] mask, input logic err, input bit lat);
        bit ok = 0;
        bit rdy;
        exp_t e;
        bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b;
        bus.cmd_shift = sh; bus.cmd_tag = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = bus.cmd_ready;
            if (rdy) begin
                e = '{res: r, flags: fl, mask: mask, tag: tag, err: err, acc: cyc, chk_lat: lat};
                exp_q.push_back(e);
                $display("cmd op=%0d a=%h b=%h sh=%0d tag=%0h cycle=%0d", op, a, b, sh, tag, cyc);
            end
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("drain", exp_q.size(), 32'd0);
    endtask

    // Continuous-valid pump used by the credit test
    int pump_tag = 0;
    int pump_acc = 0;
    task automatic pump(input int n);
        bit rdy;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            bus.cmd_opcode = 4'd0; bus.cmd_a = 32'(pump_tag); bus.cmd_b = 32'd100;
            bus.cmd_shift = 5'd0; bus.cmd_tag = 4'(pump_tag);
            @(negedge clk);
            rdy = bus.cmd_ready;
            if (rdy) begin
                e = '{res: 32'(pump_tag + 100), flags: 4'd0, mask: 4'd0, tag: 4'(pump_tag), err: 1'b0, acc: cyc, chk_lat: 1'b0};
                exp_q.push_back(e);
                $display("cmd op=0 tag=%0h cycle=%0d", pump_tag, cyc);
            end
            @(posedge clk); #1;
            if (rdy) begin
                pump_acc++;
                pump_tag++;
            end
        end
    endtask

    bit tog_en = 0;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_shift = '0; bus.cmd_tag = '0; bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_flags", {28'd0, bus.rsp_flags}, 32'd0);
        check("rst_rsp_tag", {28'd0, bus.rsp_tag}, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        check("rst_alu_input1", alu_input1, 32'd0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;

        // ADD 5+7, latency 4, ALU drive visible the cycle after accept
        send(4'd0, 32'd5, 32'd7, 5'd0, 4'd3, 32'd12, 4'b0000, 4'b1100, 1'b0, 1'b1);
        check("issue_opcode", {28'd0, alu_opcode}, 32'd0);
        check("issue_input1", alu_input1, 32'd5);
        check("issue_input2", alu_input2, 32'd7);
        drain();

        // SUB 0-1 then ADD 0xFFFFFFFF+1 back-to-back
        send(4'd1, 32'd0, 32'd1, 5'd0, 4'd1, 32'hFFFF_FFFF, 4'b1001, 4'b1001, 1'b0, 1'b0);
        send(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd2, 32'd0, 4'b1100, 4'b1100, 1'b0, 1'b0);
        drain();

        // Credit exhaustion with consumer stalled, then a single-cycle release
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        pump(10);
        check("credit_accepts", pump_acc, 32'd4);
        check("credit_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
        check("credit_busy", {31'd0, busy}, 32'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        pump(8);
        check("credit_release_accepts", pump_acc, 32'd5);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

        // Alternating ROL/SLL with the consumer toggling every cycle
        bus.rsp_ready = 1'b0;
        tog_en = 1;
        fork
            begin
                while (tog_en) begin
                    @(posedge clk); #1;
                    if (tog_en) bus.rsp_ready = ~bus.rsp_ready;
                end
            end
        join_none
        send(4'd3, 32'h8000_0001, 32'd0, 5'd1, 4'd4, 32'h0000_0003, 4'd0, 4'd0, 1'b0, 1'b0);
        send(4'd8, 32'd1, 32'd0, 5'd31, 4'd5, 32'h8000_0000, 4'd0, 4'd0, 1'b0, 1'b0);
        send(4'd3, 32'h8000_0001, 32'd0, 5'd1, 4'd6, 32'h0000_0003, 4'd0, 4'd0, 1'b0, 1'b0);
        send(4'd8, 32'd1, 32'd0, 5'd31, 4'd7, 32'h8000_0000, 4'd0, 4'd0, 1'b0, 1'b0);
        drain();
        tog_en = 0;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with three ops in flight
        send(4'd0, 32'd1, 32'd2, 5'd0, 4'd8, 32'd3, 4'd0, 4'd0, 1'b0, 1'b0);
        send(4'd0, 32'd1, 32'd3, 5'd0, 4'd9, 32'd4, 4'd0, 4'd0, 1'b0, 1'b0);
        send(4'd0, 32'd1, 32'd4, 5'd0, 4'd10, 32'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        check("inflight_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        send(4'd0, 32'd1, 32'd1, 5'd0, 4'd11, 32'd2, 4'b0000, 4'b1100, 1'b0, 1'b1);
        drain();

        // DIV by zero between two MULs
        send(4'd2, 32'd3, 32'd4, 5'd0, 4'd12, 32'd12, 4'd0, 4'd0, 1'b0, 1'b0);
`ifdef ALU_ISSUE_DIVZERO_EN
        send(4'd7, 32'd10, 32'd0, 5'd0, 4'd13, 32'hFFFF_FFFF, 4'd0, 4'hF, 1'b1, 1'b0);
        check("divzero_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        check("divzero_alu_input1", alu_input1, 32'd0);
`else
        send(4'd7, 32'd10, 32'd0, 5'd0, 4'd13, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        check("div_alu_opcode", {28'd0, alu_opcode}, 32'd7);
        check("div_alu_input1", alu_input1, 32'd10);
`endif
        send(4'd2, 32'd3, 32'd4, 5'd0, 4'd14, 32'd12, 4'd0, 4'd0, 1'b0, 1'b0);
        drain();

        repeat (6) @(posedge clk);
        #1;
        check("final_busy", {31'd0, busy}, 32'd0);
        check("final_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
